// File: rtl/led_display_if.sv
// led_display_if
//   Bundles the display-side outputs of led_display.
//   SEG   [7:0] : segment drive {dp,g,f,e,d,c,b,a}, active-low
//   SEL   [3:0] : digit select, active-low one-hot, SEL[0] = rightmost digit
//   COUNT [7:0] : current counter value, unsigned
//   master : driven by led_display
//   slave  : observed by whatever consumes the display signals
interface led_display_if;
    logic [7:0] SEG;
    logic [3:0] SEL;
    logic [7:0] COUNT;

    modport master (output SEG, output SEL, output COUNT);
    modport slave  (input SEG, input SEL, input COUNT);
endinterface

// File: rtl/led_display.sv
// led_display
//   Free-running 8-bit counter shown in decimal on a 4-digit multiplexed
//   7-segment display (hundreds/tens/ones, leftmost digit blank).
//   COUNT_DIV : CLKIN cycles per COUNT increment (1 .. 2^32-1)
//   SCAN_DIV  : CLKIN cycles per digit advance   (1 .. 2^32-1)
//   CLKIN     : system clock, rising edge
//   RESET     : asynchronous, active-low
//   disp      : SEG / SEL / COUNT outputs (led_display_if.master)
module led_display #(
    parameter int unsigned COUNT_DIV = 50000000,
    parameter int unsigned SCAN_DIV  = 50000
) (
    input  logic          CLKIN,
    input  logic          RESET,
    led_display_if.master disp
);

    logic [31:0] count_pre;
    logic [31:0] scan_pre;
    logic [7:0]  count_q;
    logic [1:0]  idx_q;

    logic [11:0] bcd;
    logic [3:0]  digit;
    logic        blank;
    logic [7:0]  seg;
    logic [3:0]  sel;

    // Count prescaler and counter; the counter steps on the prescaler wrap edge.
    always_ff @(posedge CLKIN or negedge RESET) begin
        if (!RESET) begin
            count_pre <= '0;
            count_q   <= '0;
        end else if (count_pre == COUNT_DIV - 32'd1) begin
            count_pre <= '0;
            count_q   <= count_q + 8'd1;
        end else begin
            count_pre <= count_pre + 32'd1;
        end
    end

    // Scan prescaler and digit index, independent of the count path.
    always_ff @(posedge CLKIN or negedge RESET) begin
        if (!RESET) begin
            scan_pre <= '0;
            idx_q    <= '0;
        end else if (scan_pre == SCAN_DIV - 32'd1) begin
            scan_pre <= '0;
            idx_q    <= idx_q + 2'd1;
        end else begin
            scan_pre <= scan_pre + 32'd1;
        end
    end

    // Double-dabble: shift COUNT in MSB first, adding 3 to any BCD nibble
    // that is 5 or more before each shift.
    always_comb begin
        bcd = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            for (int unsigned j = 0; j < 3; j++) begin
                if (bcd[4*j +: 4] >= 4'd5) begin
                    bcd[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
                end
            end
            bcd = {bcd[10:0], count_q[7 - i]};
        end
    end

    always_comb begin
        digit = '0;
        blank = 1'b0;
        case (idx_q)
            2'd0:    digit = bcd[3:0];
            2'd1:    digit = bcd[7:4];
            2'd2:    digit = bcd[11:8];
            default: blank = 1'b1;
        endcase
    end

    always_comb begin
        seg = '1;
        if (!blank) begin
            case (digit)
                4'd0:    seg = 8'hC0;
                4'd1:    seg = 8'hF9;
                4'd2:    seg = 8'hA4;
                4'd3:    seg = 8'hB0;
                4'd4:    seg = 8'h99;
                4'd5:    seg = 8'h92;
                4'd6:    seg = 8'h82;
                4'd7:    seg = 8'hF8;
                4'd8:    seg = 8'h80;
                4'd9:    seg = 8'h90;
                default: seg = '1;
            endcase
        end
    end

    always_comb begin
        sel = ~(4'b0001 << idx_q);
    end

    assign disp.SEG   = seg;
    assign disp.SEL   = sel;
    assign disp.COUNT = count_q;

endmodule

// File: tb/tb_led_display.sv
// tb_led_display
//   Two led_display instances share clock and reset:
//     dut_a : COUNT_DIV=10, SCAN_DIV=2
//     dut_b : COUNT_DIV=1,  SCAN_DIV=3
//   Expected outputs come from edge counts since reset release:
//   COUNT = (edges / COUNT_DIV) mod 256, index = (edges / SCAN_DIV) mod 4.
module tb_led_display;

    localparam int unsigned CDIV_A = 10;
    localparam int unsigned SDIV_A = 2;
    localparam int unsigned CDIV_B = 1;
    localparam int unsigned SDIV_B = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_display_if ifa ();
    led_display_if ifb ();

    led_display #(.COUNT_DIV(CDIV_A), .SCAN_DIV(SDIV_A)) dut_a (
        .CLKIN (clk),
        .RESET (rst_n),
        .disp  (ifa)
    );

    led_display #(.COUNT_DIV(CDIV_B), .SCAN_DIV(SDIV_B)) dut_b (
        .CLKIN (clk),
        .RESET (rst_n),
        .disp  (ifb)
    );

    logic [7:0] cnt_o [2];
    logic [7:0] seg_o [2];
    logic [3:0] sel_o [2];
    assign cnt_o[0] = ifa.COUNT;
    assign seg_o[0] = ifa.SEG;
    assign sel_o[0] = ifa.SEL;
    assign cnt_o[1] = ifb.COUNT;
    assign seg_o[1] = ifb.SEG;
    assign sel_o[1] = ifb.SEL;

    int          errors = 0;
    int          checks = 0;
    int unsigned n = 0;     // rising edges seen since reset release

    function automatic int unsigned cdiv(input int d);
        return (d == 0) ? CDIV_A : CDIV_B;
    endfunction

    function automatic int unsigned sdiv(input int d);
        return (d == 0) ? SDIV_A : SDIV_B;
    endfunction

    function automatic logic [7:0] exp_count(input int unsigned edges, input int unsigned div);
        return 8'((edges / div) % 256);
    endfunction

    function automatic logic [3:0] exp_sel(input int unsigned edges, input int unsigned div);
        logic [3:0] s;
        s = 4'b1111;
        s[(edges / div) % 4] = 1'b0;
        return s;
    endfunction

    function automatic logic [7:0] exp_seg(input int unsigned cnt, input int unsigned idx);
        logic [7:0] pat [10];
        int unsigned dig;
        pat = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        if (idx == 3) return 8'hFF;
        dig = (idx == 0) ? (cnt % 10) : (idx == 1) ? ((cnt / 10) % 10) : (cnt / 100);
        return pat[dig];
    endfunction

    // Advance one clock; leaves time at the following falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) n++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks += 3;
                if (cnt_o[d] !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_count[%0d]: got %h expected 00", d, cnt_o[d]);
                end
                if (sel_o[d] !== 4'b1110) begin
                    errors++;
                    $display("FAIL reset_sel[%0d]: got %b expected 1110", d, sel_o[d]);
                end
                if (seg_o[d] !== 8'hC0) begin
                    errors++;
                    $display("FAIL reset_seg[%0d]: got %h expected c0", d, seg_o[d]);
                end
            end
        end
    endtask

    task automatic test_count_rate();
        rst_n = 1'b1;
        for (int k = 0; k < 250; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks += 3;
                if (cnt_o[d] !== exp_count(n, cdiv(d))) begin
                    errors++;
                    $display("FAIL rate_count[%0d] n=%0d: got %h expected %h", d, n, cnt_o[d], exp_count(n, cdiv(d)));
                end
                if (sel_o[d] !== exp_sel(n, sdiv(d))) begin
                    errors++;
                    $display("FAIL rate_sel[%0d] n=%0d: got %b expected %b", d, n, sel_o[d], exp_sel(n, sdiv(d)));
                end
                if (seg_o[d] !== exp_seg(exp_count(n, cdiv(d)), (n / sdiv(d)) % 4)) begin
                    errors++;
                    $display("FAIL rate_seg[%0d] n=%0d: got %h expected %h", d, n, seg_o[d],
                             exp_seg(exp_count(n, cdiv(d)), (n / sdiv(d)) % 4));
                end
            end
            if (n == 9) begin
                checks++;
                if (cnt_o[0] !== 8'd0) begin
                    errors++;
                    $display("FAIL rate_edge9: got %0d expected 0", cnt_o[0]);
                end
            end
            if (n == 10) begin
                checks++;
                if (cnt_o[0] !== 8'd1) begin
                    errors++;
                    $display("FAIL rate_edge10: got %0d expected 1", cnt_o[0]);
                end
            end
            if (n == 250) begin
                checks++;
                if (cnt_o[0] !== 8'd25) begin
                    errors++;
                    $display("FAIL rate_edge250: got %0d expected 25", cnt_o[0]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        while (n < 256) begin
            tick();
            if (n == 255) begin
                checks++;
                if (cnt_o[1] !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255: got %0d expected 255", cnt_o[1]);
                end
            end
            if (n == 256) begin
                checks++;
                if (cnt_o[1] !== 8'd0) begin
                    errors++;
                    $display("FAIL wrap_0: got %0d expected 0", cnt_o[1]);
                end
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] seq [5];
        seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        #2 rst_n = 1'b0;
        n = 0;
        #1;
        checks++;
        if (sel_o[0] !== 4'b1110) begin
            errors++;
            $display("FAIL scan_async: got %b expected 1110", sel_o[0]);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (sel_o[0] !== seq[k / 2]) begin
                errors++;
                $display("FAIL scan_seq n=%0d: got %b expected %b", n, sel_o[0], seq[k / 2]);
            end
            tick();
        end
    endtask

    task automatic test_decode();
        logic [7:0] dec [4];
        int unsigned idx;
        dec = '{8'hB0, 8'hA4, 8'hF9, 8'hFF};
        while (n < 1230) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks += 2;
                if (cnt_o[d] !== exp_count(n, cdiv(d))) begin
                    errors++;
                    $display("FAIL dec_run_count[%0d] n=%0d: got %h expected %h", d, n, cnt_o[d], exp_count(n, cdiv(d)));
                end
                if (seg_o[d] !== exp_seg(exp_count(n, cdiv(d)), (n / sdiv(d)) % 4)) begin
                    errors++;
                    $display("FAIL dec_run_seg[%0d] n=%0d: got %h expected %h", d, n, seg_o[d],
                             exp_seg(exp_count(n, cdiv(d)), (n / sdiv(d)) % 4));
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            idx = (n / SDIV_A) % 4;
            checks += 2;
            if (cnt_o[0] !== 8'd123) begin
                errors++;
                $display("FAIL dec_count n=%0d: got %0d expected 123", n, cnt_o[0]);
            end
            if (seg_o[0] !== dec[idx]) begin
                errors++;
                $display("FAIL dec_seg idx=%0d: got %h expected %h", idx, seg_o[0], dec[idx]);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        #2 rst_n = 1'b0;
        n = 0;
        tick();
        rst_n = 1'b1;
        while (n < 75) tick();
        checks++;
        if (cnt_o[0] !== 8'd7) begin
            errors++;
            $display("FAIL mid_pre_count: got %0d expected 7", cnt_o[0]);
        end
        #3 rst_n = 1'b0;
        n = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks += 3;
            if (cnt_o[d] !== 8'h00) begin
                errors++;
                $display("FAIL mid_async_count[%0d]: got %h expected 00", d, cnt_o[d]);
            end
            if (sel_o[d] !== 4'b1110) begin
                errors++;
                $display("FAIL mid_async_sel[%0d]: got %b expected 1110", d, sel_o[d]);
            end
            if (seg_o[d] !== 8'hC0) begin
                errors++;
                $display("FAIL mid_async_seg[%0d]: got %h expected c0", d, seg_o[d]);
            end
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks += 2;
            if (cnt_o[0] !== ((k < 10) ? 8'd0 : 8'd1)) begin
                errors++;
                $display("FAIL mid_restart_a edge=%0d: got %0d expected %0d", k, cnt_o[0], (k < 10) ? 0 : 1);
            end
            if (cnt_o[1] !== 8'(k)) begin
                errors++;
                $display("FAIL mid_restart_b edge=%0d: got %0d expected %0d", k, cnt_o[1], k);
            end
        end
    endtask

    task automatic test_random();
        int unsigned run;
        int unsigned hold;
        for (int it = 0; it < 20; it++) begin
            run = $urandom_range(1, 300);
            for (int unsigned k = 0; k < run; k++) begin
                tick();
                for (int d = 0; d < 2; d++) begin
                    checks += 3;
                    if (cnt_o[d] !== exp_count(n, cdiv(d))) begin
                        errors++;
                        $display("FAIL rnd_count[%0d] n=%0d: got %h expected %h", d, n, cnt_o[d], exp_count(n, cdiv(d)));
                    end
                    if (sel_o[d] !== exp_sel(n, sdiv(d))) begin
                        errors++;
                        $display("FAIL rnd_sel[%0d] n=%0d: got %b expected %b", d, n, sel_o[d], exp_sel(n, sdiv(d)));
                    end
                    if (seg_o[d] !== exp_seg(exp_count(n, cdiv(d)), (n / sdiv(d)) % 4)) begin
                        errors++;
                        $display("FAIL rnd_seg[%0d] n=%0d: got %h expected %h", d, n, seg_o[d],
                                 exp_seg(exp_count(n, cdiv(d)), (n / sdiv(d)) % 4));
                    end
                end
            end
            // Reset pulse placed between clock edges.
            #($urandom_range(1, 2));
            rst_n = 1'b0;
            n = 0;
            #1;
            for (int d = 0; d < 2; d++) begin
                checks += 2;
                if (cnt_o[d] !== 8'h00) begin
                    errors++;
                    $display("FAIL rnd_rst_count[%0d]: got %h expected 00", d, cnt_o[d]);
                end
                if (sel_o[d] !== 4'b1110) begin
                    errors++;
                    $display("FAIL rnd_rst_sel[%0d]: got %b expected 1110", d, sel_o[d]);
                end
            end
            hold = $urandom_range(0, 3);
            if (hold == 0) begin
                #1;
            end else begin
                for (int unsigned k = 0; k < hold; k++) tick();
                #($urandom_range(1, 3));
            end
            rst_n = 1'b1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_count_rate();
        test_wrap();
        test_scan();
        test_decode();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_display.md
LED_DISPLAY -- requirements
Module: led_display

Interface
REQ-001 The block SHALL provide parameter COUNT_DIV, default 50000000: the number of CLKIN cycles per COUNT increment; legal range 1 to 2^32-1, and it is the first positional parameter.
REQ-002 The block SHALL provide parameter SCAN_DIV, default 50000: the number of CLKIN cycles per display digit advance; legal range 1 to 2^32-1.
REQ-003 CLKIN  input  1  The single system clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  Reset, asynchronous and active-low.
REQ-005 SEG  output  8  Segment drive {dp,g,f,e,d,c,b,a}, active-low (0 = segment lit).
REQ-006 SEL  output  4  Digit select, active-low one-hot; SEL[0] is the rightmost digit.
REQ-007 COUNT  output  8  Current counter value, unsigned.

Function
REQ-008 The count prescaler SHALL count 0..COUNT_DIV-1 and wrap to 0; COUNT SHALL increment by 1 on the same edge as the prescaler wraps.
REQ-009 The first COUNT increment SHALL occur on the COUNT_DIV-th rising edge after RESET deasserts; each later increment SHALL follow the previous one by exactly COUNT_DIV edges.
REQ-010 With COUNT_DIV=1, COUNT SHALL increment on every rising edge.
REQ-011 COUNT SHALL wrap from 255 to 0 with no flag and no stall.
REQ-012 The scan prescaler SHALL count 0..SCAN_DIV-1 independently of the count prescaler; on wrap, the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-013 SEL SHALL be decoded from the digit index: index 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111; exactly one bit SHALL be low at all times.
REQ-014 SEG SHALL show COUNT in decimal: index 0 = ones, index 1 = tens, index 2 = hundreds, with leading zeros shown; index 3 SHALL be blank (8'hFF).
REQ-015 The binary-to-BCD conversion SHALL be combinational from COUNT (for example, double-dabble); SEG and SEL SHALL be combinational decodes of the registered COUNT and digit index, with no added latency.
REQ-016 The digit patterns SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, with dp always off); blank is FF.
REQ-017 A COUNT increment and a digit advance on the same edge SHALL both take effect, and SEG SHALL show the new digit of the new COUNT.

Reset
REQ-018 While RESET is low, both prescalers, COUNT and the digit index SHALL be 0, so that COUNT=8'h00, SEL=4'b1110 and SEG=8'hC0.
REQ-019 Assertion of RESET SHALL take effect immediately, independent of CLKIN, including in the middle of a prescaler period.
REQ-020 After RESET deasserts, counting SHALL restart from prescaler value 0, with no partial period retained.

Verification
REQ-021 Reset check: hold RESET low with CLKIN running -> COUNT=00, SEL=1110, SEG=C0 throughout.
REQ-022 Count rate check: set COUNT_DIV=10, release RESET, run 500 ns with a 2 ns clock -> COUNT=1 after the 10th edge, and COUNT=25 after 250 edges.
REQ-023 Wrap check: set COUNT_DIV=1 and run 256 edges after reset -> COUNT goes 255 -> 0 on the 256th edge.
REQ-024 Scan check: set SCAN_DIV=2 -> SEL sequence is 1110, 1101, 1011, 0111, 1110, with each value held for 2 cycles.
REQ-025 Decode check: with COUNT=123 -> SEG=B0 at index 0, A4 at index 1, F9 at index 2 and FF at index 3.
REQ-026 Mid-operation reset check: pulse RESET low between increments while COUNT=7 -> all outputs return to their reset values asynchronously, and the next increment occurs COUNT_DIV edges after release.
